// File: rtl/seg7_pkg.sv
// Glyph codes, active-low segment patterns and the per-digit register type for seg7_scan_driver.
// The blink field of digit_t exists only when SEG7_BLINK_EN is defined.
package seg7_pkg;

    localparam logic [3:0] GLYPH_S       = 4'd0;
    localparam logic [3:0] GLYPH_T       = 4'd1;
    localparam logic [3:0] GLYPH_O_SMALL = 4'd2;
    localparam logic [3:0] GLYPH_P       = 4'd3;
    localparam logic [3:0] GLYPH_G       = 4'd4;
    localparam logic [3:0] GLYPH_O_BIG   = 4'd5;
    localparam logic [3:0] GLYPH_DASH    = 4'd6;
    localparam logic [3:0] GLYPH_BLANK   = 4'd7;

    // Bit order {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_OFF     = 7'h7F;
    localparam logic [6:0] PAT_S       = 7'h12;
    localparam logic [6:0] PAT_T       = 7'h07;
    localparam logic [6:0] PAT_O_SMALL = 7'h23;
    localparam logic [6:0] PAT_P       = 7'h0C;
    localparam logic [6:0] PAT_G       = 7'h02;
    localparam logic [6:0] PAT_O_BIG   = 7'h40;
    localparam logic [6:0] PAT_DASH    = 7'h3F;

    typedef struct packed {
        logic [3:0] glyph;
        logic       dp;
`ifdef SEG7_BLINK_EN
        logic       blink;
`endif
    } digit_t;

    localparam digit_t DIGIT_RESET = '{glyph: GLYPH_BLANK, default: '0};

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Write bus into the seg7_scan_driver digit register file.
// wr_blink is carried only when SEG7_BLINK_EN is defined.
interface seg7_scan_driver_if;

    logic       wr_en;
    logic [2:0] wr_idx;
    logic [3:0] wr_glyph;
    logic       wr_dp;
`ifdef SEG7_BLINK_EN
    logic       wr_blink;
`endif

    modport master (
        output wr_en, wr_idx, wr_glyph, wr_dp
`ifdef SEG7_BLINK_EN
        , wr_blink
`endif
    );

    modport slave (
        input wr_en, wr_idx, wr_glyph, wr_dp
`ifdef SEG7_BLINK_EN
        , wr_blink
`endif
    );

endinterface

// File: rtl/seg7_glyph_rom.sv
// Combinational glyph code to active-low 7-segment pattern decode.
// Codes 7..15 all decode to an unlit digit.
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        case (code)
            GLYPH_S:       pattern = PAT_S;
            GLYPH_T:       pattern = PAT_T;
            GLYPH_O_SMALL: pattern = PAT_O_SMALL;
            GLYPH_P:       pattern = PAT_P;
            GLYPH_G:       pattern = PAT_G;
            GLYPH_O_BIG:   pattern = PAT_O_BIG;
            GLYPH_DASH:    pattern = PAT_DASH;
            default:       pattern = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with a per-digit register file.
// Optional per-digit blinking is enabled by defining SEG7_BLINK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_scan_driver_if.slave     wr,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DIG_W = $clog2(NUM_DIGITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("seg7_scan_driver: NUM_DIGITS must be within 2..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("seg7_scan_driver: SCAN_DIV must be at least 2");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink_div
        $error("seg7_scan_driver: BLINK_DIV must be at least 2");
    end

    logic [DIV_W-1:0]      div_cnt_reg;
    logic [DIG_W-1:0]      dig_idx_reg;
    logic [6:0]            seg_reg;
    logic                  dp_reg;
    logic [NUM_DIGITS-1:0] an_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
            dig_idx_reg <= '0;
        end else if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            dig_idx_reg <= (dig_idx_reg == DIG_LAST) ? '0 : dig_idx_reg + DIG_W'(1);
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               blink_phase_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= ~blink_phase_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
        end
    end
`endif

    digit_t wr_entry;
    digit_t entries [NUM_DIGITS];

    assign wr_entry.glyph = wr.wr_glyph;
    assign wr_entry.dp    = wr.wr_dp;
`ifdef SEG7_BLINK_EN
    assign wr_entry.blink = wr.wr_blink;
`endif

    // Indices >= NUM_DIGITS match no entry, so such writes fall away naturally.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        digit_t entry_reg;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                entry_reg <= DIGIT_RESET;
            end else if (wr.wr_en && wr.wr_idx == 3'(gi)) begin
                entry_reg <= wr_entry;
            end
        end

        assign entries[gi] = entry_reg;
    end

    digit_t     cur_entry;
    logic [6:0] glyph_pattern;
    logic       hide;

    assign cur_entry = entries[dig_idx_reg];

`ifdef SEG7_BLINK_EN
    assign hide = blink_phase_reg && cur_entry.blink;
`else
    assign hide = 1'b0;
`endif

    seg7_glyph_rom u_glyph_rom (
        .code    (cur_entry.glyph),
        .pattern (glyph_pattern)
    );

    // Anodes stay off for the first cycle of every slot to hide ghosting on digit change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_reg <= SEG_OFF;
            dp_reg  <= 1'b1;
            an_reg  <= '1;
        end else begin
            if (blank || div_cnt_reg == '0) begin
                an_reg <= '1;
            end else begin
                an_reg <= ~(NUM_DIGITS'(1) << dig_idx_reg);
            end
            if (blank || hide) begin
                seg_reg <= SEG_OFF;
                dp_reg  <= 1'b1;
            end else begin
                seg_reg <= glyph_pattern;
                dp_reg  <= ~cur_entry.dp;
            end
        end
    end

    assign seg = seg_reg;
    assign dp  = dp_reg;
    assign an  = an_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed steps then random traffic against a cycle-count model.
// Blink expectations are modelled when SEG7_BLINK_EN is defined.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BD = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         blank = 1'b0;
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] an;

    seg7_scan_driver_if wr_if ();

    seg7_scan_driver #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr_if),
        .blank (blank),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: cycles elapsed since reset release plus the contents of each digit.
    int         cyc = 0;
    logic [3:0] m_glyph [N];
    logic       m_dp    [N];
    logic       m_blink [N];
    logic [6:0] glyph_tab [16];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < N; i++) begin
            m_glyph[i] = 4'd7;
            m_dp[i]    = 1'b0;
            m_blink[i] = 1'b0;
        end
    endtask

    task automatic step(input logic rst, input logic wen, input logic [2:0] idx,
                        input logic [3:0] g, input logic d, input logic bl,
                        input logic blk, input string tag);
        logic [N-1:0] e_an;
        logic [6:0]   e_seg;
        logic         e_dp;
        bit           chk_seg;
        bit           chk_dp;
        bit           hidden;
        int           slot_pos;
        int           digit;
        rst_n          = rst;
        wr_if.wr_en    = wen;
        wr_if.wr_idx   = idx;
        wr_if.wr_glyph = g;
        wr_if.wr_dp    = d;
`ifdef SEG7_BLINK_EN
        wr_if.wr_blink = bl;
`endif
        blank          = blk;
        slot_pos = cyc % SD;
        digit    = (cyc / SD) % N;
        hidden   = 1'b0;
`ifdef SEG7_BLINK_EN
        hidden = ((cyc / BD) % 2 == 1) && m_blink[digit];
`endif
        e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; chk_seg = 1'b1; chk_dp = 1'b1;
        if (rst && blk) begin
            chk_dp = 1'b0;
        end else if (rst && slot_pos == 0) begin
            chk_seg = 1'b0;
            chk_dp  = 1'b0;
        end else if (rst) begin
            e_an = ~(N'(1) << digit);
            if (!hidden) begin
                e_seg = glyph_tab[m_glyph[digit]];
                e_dp  = ~m_dp[digit];
            end
        end
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            cyc++;
            if (wen && int'(idx) < N) begin
                m_glyph[idx] = g;
                m_dp[idx]    = d;
                m_blink[idx] = bl;
            end
        end
        #1;
        check({tag, "_an"}, 8'(an), 8'(e_an));
        if (chk_seg) check({tag, "_seg"}, 8'(seg), 8'(e_seg));
        if (chk_dp)  check({tag, "_dp"}, 8'(dp), 8'(e_dp));
        $display("step %-8s cyc=%0d wr=%b idx=%0d g=%0d blank=%b -> an=%h seg=%h dp=%b",
                 tag, cyc, wen, idx, g, blk, an, seg, dp);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) glyph_tab[i] = 7'h7F;
        glyph_tab[0] = 7'h12; glyph_tab[1] = 7'h07; glyph_tab[2] = 7'h23; glyph_tab[3] = 7'h0C;
        glyph_tab[4] = 7'h02; glyph_tab[5] = 7'h40; glyph_tab[6] = 7'h3F;
        model_reset();
        wr_if.wr_en = 1'b0; wr_if.wr_idx = '0; wr_if.wr_glyph = '0; wr_if.wr_dp = 1'b0;
`ifdef SEG7_BLINK_EN
        wr_if.wr_blink = 1'b0;
`endif

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, "reset");
        check("reset_seg", 8'(seg), 8'h7F);
        check("reset_an", 8'(an), 8'h0F);
        idle(16, "scan");

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'(i), 4'(i), (i == 2), 1'b0, 1'b0, "write");
        idle(20, "show");

        step(1'b1, 1'b1, 3'd5, 4'd4, 1'b1, 1'b0, 1'b0, "ign_wr");
        idle(16, "ign_show");

        for (int i = 0; i < 2 * SD * N && (cyc % (SD * N)) != 1; i++) idle(1, "align");
        check("align_done", 8'(cyc % (SD * N)), 8'd1);
        step(1'b1, 1'b1, 3'd0, 4'd5, 1'b0, 1'b0, 1'b0, "wr_disp");
        idle(1, "wr_disp");
        check("wr_disp_40", 8'(seg), 8'h40);
        idle(6, "after");

        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, "blank");
        idle(16, "resume");

        step(1'b1, 1'b1, 3'd1, 4'd6, 1'b0, 1'b1, 1'b0, "blink");
        idle(40, "blink");

        idle(5, "pre_rst");
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, "mid_rst");
        idle(20, "post_rst");

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(63) != 0), ($urandom_range(2) == 0), 3'($urandom_range(7)),
                 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 ($urandom_range(7) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode 7-segment display. It holds one glyph code and decimal point per digit in a small register file written by the control logic. It scans the digits at a programmable rate and drives active-low segment and anode lines. It is the multi-digit, clocked successor to the single-digit switch-to-letter decoder, and it sits between the game/status FSM and the board display pins.

## Interface
- NUM_DIGITS, 4: number of digits scanned (2..8).
- SCAN_DIV, 100000: clock cycles per digit slot (≥2).
- BLINK_DIV, 25000000: clock cycles per blink half-period. Used only with SEG7_BLINK_EN.
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active low.
- wr_en  in  1  write strobe for the digit register file.
- wr_idx  in  3  target digit. Writes with wr_idx ≥ NUM_DIGITS are ignored.
- wr_glyph  in  4  glyph code.
- wr_dp  in  1  decimal point for the digit (1 = lit).
- wr_blink  in  1  blink enable for the digit. Present only with SEG7_BLINK_EN.
- blank  in  1  global blank. While high, all anodes are off.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low.
- an  out  NUM_DIGITS  digit anodes, active low; an[0] is the rightmost digit.

## Operation
- Glyph codes: 0 S (a,c,d,f,g); 1 t (d,e,f,g); 2 o (c,d,e,g); 3 P (a,b,e,f,g); 4 G (a,c,d,e,f,g); 5 O (a,b,c,d,e,f); 6 '-' (g); 7..15 blank (no segments lit).
- Register file: per digit, 4-bit glyph, dp bit, and blink bit (blink only with the macro). Reset value of every entry: glyph 7, dp 0, blink 0.
- A write is accepted in any cycle with wr_en=1. There is no backpressure.
- div_cnt counts 0..SCAN_DIV-1 and then wraps to 0. On the cycle where div_cnt = SCAN_DIV-1, dig_idx advances to dig_idx+1. dig_idx wraps from NUM_DIGITS-1 to 0.
- Ghost blanking: during the first cycle of each slot (div_cnt = 0), all anodes are off.
- Active digit: an[dig_idx]=0 and all other anodes are 1. seg and dp come from the ROM decode of entry[dig_idx].
- blank=1 forces an to all ones and seg to 7'h7F. Counters keep running.
- Simultaneous write to the digit being displayed: the new value appears on the outputs with normal write latency. No tearing occurs within a cycle.

## Timing
- All outputs are registered.
- Reset values: seg=7'h7F, dp=1, an=all ones. Internal state: div_cnt=0, dig_idx=0, blink phase=0.
- Write latency: a write at cycle T appears on seg/dp at T+2 (register file at T+1, output register at T+2), provided that digit is active.
- Output latency from counter state: one cycle. an reflects the div_cnt/dig_idx of the previous cycle.
- Reset asserted mid-scan: on the next edge, all state returns to reset values, including register file contents.
- The first slot after reset release drives digit 0.

## Configuration
- SEG7_BLINK_EN defined:
  - Adds the wr_blink port, the per-digit blink bit, and a BLINK_DIV counter that toggles blink phase.
  - When blink phase is 1, digits with blink=1 are forced blank (seg=7'h7F, dp=1) while their anode timing is unchanged.
  - Blink phase resets to 0, so digits are visible first.
- SEG7_BLINK_EN undefined: no wr_blink port, no blink counter, no blink bit. All digits are always visible.

## Structure
- seg7_pkg holds:
  - glyph code localparams (GLYPH_S … GLYPH_DASH, GLYPH_BLANK=7);
  - SEG_OFF=7'h7F;
  - the segment pattern constants for each glyph.
- Sub-module seg7_glyph_rom: combinational 4-bit code → 7-bit active-low pattern.
- Everything else lives in seg7_scan_driver: counters, register file, output registers.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=8 unless noted.
- Reset: hold rst_n=0 for 3 cycles → seg=7'h7F, dp=1, an=4'hF. After release, an pattern per slot is F,E,E,E then F,D,D,D, and so on.
- Writes: idx0..3 ← codes 0,1,2,3 with dp on idx2. Over one full scan, observe 7'h12 on an=E, 7'h07 on an=D, 7'h23 plus dp=0 on an=B, and 7'h0C on an=7.
- Ignored write: wr_idx=5 with code 4 → no register changes, and the output sequence is identical to before.
- Write while displayed: write idx0 ← code 5 while an=E → seg=7'h40 exactly 2 cycles later.
- Blank: pulse blank for 6 cycles → an=F during those cycles, seg=7'h7F. The scan resumes at the same slot position as if it had never been blanked.
- SEG7_BLINK_EN: set blink on idx1 → digit 1 alternates visible/blank every 8 cycles, starting visible after reset. Other digits are unaffected.
